fir_cmplx_decim: RTL and testbench

- Complex decimating channel FIR directly downstream of the I/Q reader stage.
- Pops quantized I and Q samples (Q-format, BITS fractional bits) from the reader's two output FIFOs.
- Filters with a complex coefficient set and emits one filtered I/Q pair per DECIM input pairs.
- Writes results into two output FIFOs that feed the FM demodulator.

---
 rtl/fir_cmplx_decim.sv | 121 ++++++++++++
 tb/tb_fir_cmplx_decim.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cmplx_decim.sv
// Complex decimating channel FIR: loads DECIM I/Q pairs, runs one complex tap per
// cycle over the full TAPS history, then writes one filtered I/Q pair downstream.
module fir_cmplx_decim #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int TAPS      = 20,
  parameter int DECIM     = 10,
  parameter logic signed [DATA_SIZE-1:0] COEFF_REAL [TAPS] = '{
    -2, -4, -3, 4, 16, 33, 53, 72, 86, 93, 93, 86, 72, 53, 33, 16, 4, -3, -4, -2},
  parameter logic signed [DATA_SIZE-1:0] COEFF_IMAG [TAPS] = '{
    1, 2, 3, 2, -1, -5, -9, -12, -14, -15, -15, -14, -12, -9, -5, -1, 2, 3, 2, 1}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_in_empty,
  output logic                 i_in_rd_en,
  input  logic [DATA_SIZE-1:0] i_in_dout,
  input  logic                 q_in_empty,
  output logic                 q_in_rd_en,
  input  logic [DATA_SIZE-1:0] q_in_dout,
  input  logic                 i_out_full,
  output logic                 i_out_wr_en,
  output logic [DATA_SIZE-1:0] i_out_din,
  input  logic                 q_out_full,
  output logic                 q_out_wr_en,
  output logic [DATA_SIZE-1:0] q_out_din
);
  localparam int PW = 2 * DATA_SIZE;
  localparam int CW = $clog2(TAPS + 1);
  localparam int LW = $clog2(DECIM + 1);
  localparam logic signed [PW-1:0] RND = PW'((1 << BITS) - 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_WRITE} state_t;

  state_t                      state;
  logic signed [DATA_SIZE-1:0] x_r [TAPS];
  logic signed [DATA_SIZE-1:0] x_i [TAPS];
  logic [CW-1:0]               tap;
  logic [LW-1:0]               ld;
  logic signed [DATA_SIZE-1:0] acc_r, acc_i, acc_r_nxt, acc_i_nxt;
  logic                        pop, push;

  function automatic logic signed [PW-1:0] mul(input logic signed [DATA_SIZE-1:0] a,
                                                input logic signed [DATA_SIZE-1:0] b);
    logic signed [PW-1:0] ea, eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  // Divide by 2^BITS rounding toward zero, then wrap to DATA_SIZE bits.
  function automatic logic signed [DATA_SIZE-1:0] dq(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = p + (p[PW-1] ? RND : '0);
    t = t >>> BITS;
    return t[DATA_SIZE-1:0];
  endfunction

  // Handshakes are combinational so the flags are honoured in the cycle they are seen.
  assign pop  = reset && (state == S_LOAD) && !i_in_empty && !q_in_empty;
  assign push = reset && (state == S_WRITE) && !i_out_full && !q_out_full;
  assign i_in_rd_en  = pop;
  assign q_in_rd_en  = pop;
  assign i_out_wr_en = push;
  assign q_out_wr_en = push;

  assign acc_r_nxt = acc_r + dq(mul(COEFF_REAL[tap], x_r[tap])) - dq(mul(COEFF_IMAG[tap], x_i[tap]));
  assign acc_i_nxt = acc_i + dq(mul(COEFF_REAL[tap], x_i[tap])) + dq(mul(COEFF_IMAG[tap], x_r[tap]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_LOAD;
      tap       <= '0;
      ld        <= '0;
      acc_r     <= '0;
      acc_i     <= '0;
      i_out_din <= '0;
      q_out_din <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
        x_i[k] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (pop) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              x_r[k] <= x_r[k-1];
              x_i[k] <= x_i[k-1];
            end
            x_r[0] <= i_in_dout;
            x_i[0] <= q_in_dout;
            if (ld == LW'(DECIM - 1)) begin
              ld    <= '0;
              tap   <= '0;
              acc_r <= '0;
              acc_i <= '0;
              state <= S_MAC;
            end else begin
              ld <= ld + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc_r <= acc_r_nxt;
          acc_i <= acc_i_nxt;
          if (tap == CW'(TAPS - 1)) begin
            tap       <= '0;
            i_out_din <= acc_r_nxt;
            q_out_din <= acc_i_nxt;
            state     <= S_WRITE;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        S_WRITE: if (push) state <= S_LOAD;
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Directed bench: FIFO models around a 20-tap/decim-10 instance and a 1-tap/decim-1
// instance driven from a vector table for the rounding cases.
module tb_fir_cmplx_decim;
  localparam logic signed [31:0] CR [20] = '{
    40, 45, 50, 55, 60, 65, 70, 75, 80, 85, 90, 95, 100, 105, 110, 115, 120, 125, 130, 135};
  localparam logic signed [31:0] CI [20] = '{
    20, 17, 14, 11, 8, 5, 2, -1, -4, -7, -10, -13, -16, -19, -22, -25, -28, -31, -34, -37};
  localparam logic signed [31:0] TCR [1] = '{3};
  localparam logic signed [31:0] TCI [1] = '{0};

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        i_in_empty = 1'b1, q_in_empty = 1'b1, i_in_rd_en, q_in_rd_en;
  logic [31:0] i_in_dout = '0, q_in_dout = '0;
  logic        i_out_full = 1'b0, q_out_full = 1'b0, i_out_wr_en, q_out_wr_en;
  logic [31:0] i_out_din, q_out_din;

  logic        t_i_in_empty = 1'b1, t_q_in_empty = 1'b1, t_i_in_rd_en, t_q_in_rd_en;
  logic [31:0] t_i_in_dout = '0, t_q_in_dout = '0;
  logic        t_i_out_wr_en, t_q_out_wr_en;
  logic [31:0] t_i_out_din, t_q_out_din;

  fir_cmplx_decim #(.DATA_SIZE(32), .BITS(10), .TAPS(20), .DECIM(10),
                    .COEFF_REAL(CR), .COEFF_IMAG(CI)) dut (
    .clock(clock), .reset(reset),
    .i_in_empty(i_in_empty), .i_in_rd_en(i_in_rd_en), .i_in_dout(i_in_dout),
    .q_in_empty(q_in_empty), .q_in_rd_en(q_in_rd_en), .q_in_dout(q_in_dout),
    .i_out_full(i_out_full), .i_out_wr_en(i_out_wr_en), .i_out_din(i_out_din),
    .q_out_full(q_out_full), .q_out_wr_en(q_out_wr_en), .q_out_din(q_out_din));

  fir_cmplx_decim #(.DATA_SIZE(32), .BITS(10), .TAPS(1), .DECIM(1),
                    .COEFF_REAL(TCR), .COEFF_IMAG(TCI)) tiny (
    .clock(clock), .reset(reset),
    .i_in_empty(t_i_in_empty), .i_in_rd_en(t_i_in_rd_en), .i_in_dout(t_i_in_dout),
    .q_in_empty(t_q_in_empty), .q_in_rd_en(t_q_in_rd_en), .q_in_dout(t_q_in_dout),
    .i_out_full(1'b0), .i_out_wr_en(t_i_out_wr_en), .i_out_din(t_i_out_din),
    .q_out_full(1'b0), .q_out_wr_en(t_q_out_wr_en), .q_out_din(t_q_out_din));

  typedef struct { int i; int q; int ei; int eq; } vec_t;

  int          tests = 0, fails = 0;
  logic [31:0] iq[$], qq[$], oi[$], oq[$], ri[$], rq[$];
  int          wr_cyc[$], blk_cyc[$];
  int          cyc = 0, pop_cnt = 0, proto_err = 0, starve_viol = 0;
  bit          starve_q = 1'b0, pop_now = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Observe handshakes mid-cycle; the transfer happens at the following rising edge.
  always @(negedge clock) begin
    if (i_in_rd_en !== q_in_rd_en || i_out_wr_en !== q_out_wr_en) proto_err <= proto_err + 1;
    else if ((i_in_rd_en && (i_in_empty || q_in_empty)) ||
             (i_out_wr_en && (i_out_full || q_out_full))) proto_err <= proto_err + 1;
    pop_now <= (i_in_rd_en === 1'b1);
    if (i_in_rd_en === 1'b1) begin
      pop_cnt <= pop_cnt + 1;
      if ((pop_cnt + 1) % 10 == 0) blk_cyc.push_back(cyc);
      if (starve_q) starve_viol <= starve_viol + 1;
    end
    if (i_out_wr_en === 1'b1) begin
      oi.push_back(i_out_din);
      oq.push_back(q_out_din);
      wr_cyc.push_back(cyc);
    end
  end

  // FWFT upstream FIFO model
  always @(posedge clock) begin
    #2;
    if (pop_now && iq.size() > 0 && qq.size() > 0) begin
      void'(iq.pop_front());
      void'(qq.pop_front());
    end
    i_in_empty = (iq.size() == 0);
    q_in_empty = (qq.size() == 0) || starve_q;
    i_in_dout  = (iq.size() == 0) ? '0 : iq[0];
    q_in_dout  = (qq.size() == 0) ? '0 : qq[0];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h), expected %0d", nm, $signed(act), act, $signed(exp));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic clear_outs();
    oi.delete(); oq.delete(); wr_cyc.delete(); blk_cyc.delete();
  endtask

  task automatic push_pair(input int i, input int q);
    iq.push_back(i);
    qq.push_back(q);
  endtask

  task automatic push_p(input int n);
    for (int k = 0; k < n; k++) push_pair(((k * 337) % 4001) - 2000, ((k * 211) % 3001) - 1500);
  endtask

  task automatic wait_outs(input int n, input int budget, input string nm);
    int k = 0;
    while (oi.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(nm, 32'(oi.size()), 32'(n));
  endtask

  task automatic cmp_ref(input string nm);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_i%0d", nm, k), (k < oi.size()) ? oi[k] : 32'hDEAD_BEEF, ri[k]);
      check($sformatf("%s_q%0d", nm, k), (k < oq.size()) ? oq[k] : 32'hDEAD_BEEF, rq[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vt[8];
    int          base, snap_pop, wr_err, din_err, got;
    logic [31:0] snap_i, snap_q, gi, gq;

    // Reset state with data already waiting upstream
    push_p(30);
    tick(3);
    @(negedge clock);
    check("reset_rd_en", {31'b0, i_in_rd_en}, 0);
    check("reset_wr_en", {31'b0, i_out_wr_en}, 0);
    check("reset_i_din", i_out_din, 0);
    check("reset_q_din", q_out_din, 0);
    tick(1);
    reset = 1'b1;

    // Unstalled reference run
    wait_outs(3, 200, "ref_count");
    ri = oi;
    rq = oq;
    for (int b = 0; b < 3; b++)
      check($sformatf("latency%0d", b),
            (b < wr_cyc.size() && b < blk_cyc.size()) ? 32'(wr_cyc[b] - blk_cyc[b]) : 32'hFFFF_FFFF, 21);
    check("period", (wr_cyc.size() > 1) ? 32'(wr_cyc[1] - wr_cyc[0]) : 32'hFFFF_FFFF, 31);

    // Impulse through zero history
    do_reset();
    clear_outs();
    push_pair(1024, 0);
    for (int k = 0; k < 29; k++) push_pair(0, 0);
    wait_outs(3, 200, "imp_count");
    tick(40);
    check("imp_exact3", 32'(oi.size()), 3);
    check("imp0_i", oi[0], 85);   check("imp0_q", oq[0], -7);
    check("imp1_i", oi[1], 135);  check("imp1_q", oq[1], -37);
    check("imp2_i", oi[2], 0);    check("imp2_q", oq[2], 0);

    // DC 1.0+1.0j: partial history in out0, full sums afterwards
    clear_outs();
    for (int k = 0; k < 40; k++) push_pair(1024, 1024);
    wait_outs(4, 300, "dc_count");
    check("dc0_i", oi[0], 560);   check("dc0_q", oq[0], 690);
    check("dc1_i", oi[1], 1920);  check("dc1_q", oq[1], 1580);
    check("dc3_i", oi[3], 1920);  check("dc3_q", oq[3], 1580);

    // Backpressure at the first write, then Q starvation
    do_reset();
    clear_outs();
    i_out_full = 1'b1;
    base = pop_cnt;
    push_p(30);
    tick(40);
    check("hold_loaded", 32'(pop_cnt - base), 10);
    snap_pop = pop_cnt;
    snap_i = i_out_din;
    snap_q = q_out_din;
    wr_err = 0;
    din_err = 0;
    repeat (50) begin
      @(negedge clock);
      if (i_out_wr_en !== 1'b0 || q_out_wr_en !== 1'b0) wr_err++;
      if (i_out_din !== snap_i || q_out_din !== snap_q) din_err++;
    end
    tick(1);
    check("hold_no_wr", 32'(wr_err), 0);
    check("hold_din_stable", 32'(din_err), 0);
    check("hold_no_pop", 32'(pop_cnt - snap_pop), 0);
    i_out_full = 1'b0;
    starve_q = 1'b1;
    snap_pop = pop_cnt;
    tick(20);
    check("release_one_write", 32'(oi.size()), 1);
    check("starve_no_pop", 32'(pop_cnt - snap_pop), 0);
    check("starve_rd_en", 32'(starve_viol), 0);
    starve_q = 1'b0;
    wait_outs(3, 200, "stall_count");
    cmp_ref("stall");

    // Reset in the middle of S_MAC
    clear_outs();
    base = pop_cnt;
    push_p(10);
    for (int k = 0; k < 100 && pop_cnt - base < 10; k++) tick(1);
    check("mac_loaded", 32'(pop_cnt - base), 10);
    tick(14);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(40);
    check("mac_reset_no_wr", 32'(oi.size()), 0);
    push_p(30);
    wait_outs(3, 200, "post_reset_count");
    cmp_ref("post_reset");

    // Single-tap rounding vectors: I' = trunc(3*I/1024), Q' = trunc(3*Q/1024)
    vt[0] = '{-1, 1, 0, 0};
    vt[1] = '{-2048, 0, -6, 0};
    vt[2] = '{1024, -1024, 3, -3};
    vt[3] = '{-1025, 1025, -3, 3};
    vt[4] = '{341, -342, 0, -1};
    vt[5] = '{-1366, 1366, -4, 4};
    vt[6] = '{-341, 342, 0, 1};
    vt[7] = '{2000000, -2000000, 5859, -5859};
    for (int n = 0; n < 8; n++) begin
      t_i_in_dout = vt[n].i;
      t_q_in_dout = vt[n].q;
      t_i_in_empty = 1'b0;
      t_q_in_empty = 1'b0;
      tick(1);
      t_i_in_empty = 1'b1;
      t_q_in_empty = 1'b1;
      got = 0;
      gi = 'x;
      gq = 'x;
      for (int w = 0; w < 6 && got == 0; w++) begin
        @(negedge clock);
        if (t_i_out_wr_en === 1'b1 && t_q_out_wr_en === 1'b1) begin
          got = 1;
          gi = t_i_out_din;
          gq = t_q_out_din;
        end
      end
      tick(1);
      check($sformatf("tiny%0d_wr", n), 32'(got), 1);
      check($sformatf("tiny%0d_i", n), gi, vt[n].ei);
      check($sformatf("tiny%0d_q", n), gq, vt[n].eq);
    end

    check("protocol", 32'(proto_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
